product_accumulator: RTL and testbench

- Downstream consumer of the 4x4 shift-add multiplier's product stream.
- Accepts one product per beat over a valid/ready handshake and sums a programmable-length frame of products into a wider saturating accumulator.
- Presents the frame result on a registered valid/ready output port.
- Forms the accumulate half of a multiply-accumulate datapath.

---
 rtl/product_accumulator_pkg.sv | 15 +
 rtl/product_accumulator_if.sv | 40 ++++
 rtl/product_accumulator_sat_add.sv | 19 +
 rtl/product_accumulator.sv | 110 +++++++++++
 tb/tb_product_accumulator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
// Widths match the 4x4 shift-add multiplier feeding it.
package product_accumulator_pkg;

  localparam int PW_D    = 8;
  localparam int AW_D    = 10;
  localparam int LEN_W_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, frame control and result port.
// The producer/consumer side uses master, the accumulator slave.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PW    = PW_D,
  parameter int AW    = AW_D,
  parameter int LEN_W = LEN_W_D
);

  logic             clear;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_sum;
  logic             out_ovf;
  logic [LEN_W:0]   out_beats;

  modport master (
    output clear, frame_len,
    output in_valid, in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sum,
    input  out_ovf, out_beats
  );

  modport slave (
    input  clear, frame_len,
    input  in_valid, in_prod,
    input  out_ready,
    output in_ready,
    output out_valid, out_sum,
    output out_ovf, out_beats
  );

endinterface

// File: rtl/product_accumulator_sat_add.sv
// Saturating add of a zero-extended product onto the accumulator.
// Purely combinational; carry reports that the sum was clamped.
module sat_add #(
  parameter int PW = 8,
  parameter int AW = 10
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] opnd,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [AW:0] raw;

  assign raw   = {1'b0, acc} + (AW+1)'(opnd);
  assign carry = raw[AW];
  assign sum   = carry ? '1 : raw[AW-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmable-length frame of products into a saturating
// accumulator and presents the result on a registered output port.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PW    = PW_D,
  parameter int AW    = AW_D,
  parameter int LEN_W = LEN_W_D
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);

  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};

  state_t         state, state_n;
  logic [AW-1:0]  acc, acc_n, add_sum;
  logic           ovf, ovf_n, add_c;
  logic [LEN_W:0] cnt, cnt_n;
  logic [LEN_W:0] len, len_n, first_len;
  logic           accept, take, load;

  sat_add #(.PW(PW), .AW(AW)) u_add (
    .acc   (acc),
    .opnd  (bus.in_prod),
    .sum   (add_sum),
    .carry (add_c)
  );

  assign first_len = (bus.frame_len == '0)
                   ? FULL : {1'b0, bus.frame_len};

  assign bus.in_ready = !rst && !bus.clear
                      && (state != HOLD || bus.out_ready);

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cnt_n   = cnt;
    len_n   = len;
    load    = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        // HOLD doubles as IDLE so a take plus beat has no bubble
        if (accept) begin
          acc_n   = AW'(bus.in_prod);
          ovf_n   = 1'b0;
          cnt_n   = ONE;
          len_n   = first_len;
          state_n = (first_len == ONE) ? HOLD : ACCUM;
          load    = (first_len == ONE);
        end else if (state == HOLD && take) begin
          state_n = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = add_sum;
          ovf_n = ovf | add_c;
          cnt_n = cnt + ONE;
          if (cnt_n == len) begin
            state_n = HOLD;
            load    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      len           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_beats <= '0;
    end else if (bus.clear) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cnt   <= cnt_n;
      len   <= len_n;
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_sum   <= acc_n;
        bus.out_ovf   <= ovf_n;
        bus.out_beats <= cnt_n;
      end else if (take) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a frame-result
// scoreboard fed by a reference model of the accepted beats.
module tb_product_accumulator;

  typedef struct {
    int sum;
    int ovf;
    int beats;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  int m_acc;
  int m_ovf;
  int m_cnt;
  int m_len;

  product_accumulator_if ifc ();

  product_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_beat(input int p, input int fl);
    int s;
    if (m_cnt == 0) begin
      m_len = (fl == 0) ? 16 : fl;
      m_acc = p;
      m_ovf = 0;
      m_cnt = 1;
    end else begin
      s = m_acc + p;
      if (s > 1023) begin
        m_acc = 1023;
        m_ovf = 1;
      end else begin
        m_acc = s;
      end
      m_cnt++;
    end
    if (m_cnt == m_len) begin
      q.push_back('{m_acc, m_ovf, m_cnt});
      m_cnt = 0;
    end
  endtask

  // called at a falling edge; returns at the falling edge after accept
  task automatic send(input int p, input int fl);
    int n;
    n = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_prod   = 8'(p);
    ifc.frame_len = 4'(fl);
    #1;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ifc.in_ready) begin
      chk("in_ready_wait", 32'(ifc.in_ready), 1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_beat(p, fl);
    @(negedge clk);
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(ifc.out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("sb_sum", 32'(ifc.out_sum), e.sum);
        chk("sb_ovf", 32'(ifc.out_ovf), e.ovf);
        chk("sb_beats", 32'(ifc.out_beats), e.beats);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    m_acc = 0;
    m_ovf = 0;
    m_cnt = 0;
    m_len = 0;
    rst = 1'b1;
    ifc.clear     = 1'b0;
    ifc.frame_len = '0;
    ifc.in_valid  = 1'b0;
    ifc.in_prod   = '0;
    ifc.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_out_sum", 32'(ifc.out_sum), 0);
    chk("rst_out_beats", 32'(ifc.out_beats), 0);
    chk("rst_in_ready", 32'(ifc.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three beats, latency one cycle
    send(32, 3);
    send(225, 3);
    send(1, 3);
    idle();
    #2;
    chk("t1_valid", 32'(ifc.out_valid), 1);
    chk("t1_sum", 32'(ifc.out_sum), 258);
    chk("t1_ovf", 32'(ifc.out_ovf), 0);
    chk("t1_beats", 32'(ifc.out_beats), 3);
    @(negedge clk);
    @(negedge clk);

    // 2: saturation then a fresh len=1 frame
    for (int i = 0; i < 5; i++) send(225, 5);
    send(7, 1);
    idle();
    #2;
    chk("t2_sum", 32'(ifc.out_sum), 7);
    chk("t2_ovf", 32'(ifc.out_ovf), 0);
    @(negedge clk);
    @(negedge clk);

    // 3: back-pressure, then take with simultaneous beat
    send(10, 2);
    send(20, 2);
    idle();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_in_ready", 32'(ifc.in_ready), 0);
      chk("t3_hold_valid", 32'(ifc.out_valid), 1);
      chk("t3_hold_sum", 32'(ifc.out_sum), 30);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    send(9, 1);
    idle();
    #2;
    chk("t3_no_bubble", 32'(ifc.out_valid), 1);
    chk("t3_sum", 32'(ifc.out_sum), 9);
    @(negedge clk);
    @(negedge clk);

    // 4: frame_len=0 means sixteen beats, with gaps
    for (int i = 0; i < 16; i++) begin
      send(1, 0);
      idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    #2;
    chk("t4_sum", 32'(ifc.out_sum), 16);
    chk("t4_beats", 32'(ifc.out_beats), 16);
    @(negedge clk);
    @(negedge clk);

    // 5: clear mid-frame drops the presented beat
    send(50, 4);
    send(60, 4);
    ifc.clear    = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_prod  = 8'd70;
    #1;
    chk("t5_clear_ready", 32'(ifc.in_ready), 0);
    @(negedge clk);
    ifc.clear = 1'b0;
    idle();
    m_cnt = 0;
    #2;
    chk("t5_valid", 32'(ifc.out_valid), 0);
    chk("t5_sum_held", 32'(ifc.out_sum), 16);
    @(negedge clk);
    send(5, 1);
    idle();
    #2;
    chk("t5_sum", 32'(ifc.out_sum), 5);
    chk("t5_beats", 32'(ifc.out_beats), 1);
    @(negedge clk);
    @(negedge clk);

    // 6: reset while holding a result
    ifc.out_ready = 1'b0;
    send(32, 3);
    send(225, 3);
    send(1, 3);
    idle();
    #2;
    chk("t6_hold_sum", 32'(ifc.out_sum), 258);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(ifc.in_ready), 0);
    @(negedge clk);
    #2;
    chk("t6_valid", 32'(ifc.out_valid), 0);
    chk("t6_sum", 32'(ifc.out_sum), 0);
    chk("t6_beats", 32'(ifc.out_beats), 0);
    chk("t6_ready_low", 32'(ifc.in_ready), 0);
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    chk("t6_ready_high", 32'(ifc.in_ready), 1);
    @(negedge clk);
    @(negedge clk);

    chk("sb_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
